// File: rtl/estado_pkg.sv
// Shared types and constants for the 3-bit state register controller.
package estado_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t STATE_RST = 3'b000;

    localparam int DIV_DEF    = 50_000_000;
    localparam int DB_CYC_DEF = 1_000_000;

    function automatic logic [7:0] onehot8(input state_t s);
        return 8'b1 << s;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge pulse.
module sync_debounce #(
    parameter int DB_CYC = estado_pkg::DB_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC - 1);

    logic          s1;
    logic          btn_s;
    logic          level_q;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= din;
            btn_s <= s1;
        end
    end

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_MAX) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/estado_reg_ctrl.sv
// Current-state register of the up/down machine: prescaled or
// single-step loading of pe, switch synchronizers and LED decode.
module estado_reg_ctrl
    import estado_pkg::*;
#(
    parameter int DIV    = DIV_DEF,
    parameter int DB_CYC = DB_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_in,
    input  logic       run_in,
    input  logic       step_btn,
    input  logic       pe0,
    input  logic       pe1,
    input  logic       pe2,
    output logic       ea0,
    output logic       ea1,
    output logic       ea2,
    output logic       up,
    output logic       moved,
    output logic [7:0] led
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    logic          up_s1;
    logic          up_s;
    logic          run_s1;
    logic          run_s;
    logic          step_p;
    logic          db_level_unused;
    logic          tick;
    logic          load;
    logic [DW-1:0] div_cnt;
    state_t        ea;
    state_t        pe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_s1  <= 1'b0;
            up_s   <= 1'b0;
            run_s1 <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            up_s1  <= up_in;
            up_s   <= up_s1;
            run_s1 <= run_in;
            run_s  <= run_s1;
        end
    end

    sync_debounce #(
        .DB_CYC (DB_CYC)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (step_btn),
        .level (db_level_unused),
        .rise  (step_p)
    );

    // Presses in run mode are dropped; a coinciding tick loads once.
    assign tick = run_s & (div_cnt == DIV_MAX);
    assign load = tick | (step_p & ~run_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run_s || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pe = {pe2, pe1, pe0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea    <= STATE_RST;
            moved <= 1'b0;
        end else begin
            moved <= load;
            if (load) begin
                ea <= pe;
            end
        end
    end

    assign {ea2, ea1, ea0} = ea;
    assign up  = up_s;
    assign led = onehot8(ea);

endmodule
